// File: rtl/datapath_seq.sv
// Parametrised execution datapath (register file, operand latches, shifter, ALU,
// status, C register, writeback mux) driven by a start/busy/done command sequencer.
module datapath_seq #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int PCW   = 8,
    localparam int RW   = $clog2(NREGS),
    localparam int SW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [RW-1:0]    rn,
    input  logic [RW-1:0]    rm,
    input  logic [RW-1:0]    rd,
    input  logic [1:0]       ALUop,
    input  logic [1:0]       shift,
    input  logic [SW-1:0]    shamt,
    input  logic             asel,
    input  logic             bsel,
    input  logic [WIDTH-1:0] imm,
    input  logic [3:0]       vsel,
    input  logic             wb_en,
    input  logic             loads,
    input  logic [WIDTH-1:0] mdata,
    input  logic [PCW-1:0]   PC,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] datapath_out,
    output logic [2:0]       Z_out
);

    localparam int MSB = WIDTH - 1;

    typedef enum logic [2:0] {IDLE, READA, READB, EXEC, WB} state_t;

    state_t           state;
    logic [WIDTH-1:0] regs [NREGS];
    logic [WIDTH-1:0] a_reg, b_reg, c_reg;
    logic [2:0]       status;

    logic [RW-1:0]    c_rn, c_rm, c_rd;
    logic [1:0]       c_aluop, c_shift;
    logic [SW-1:0]    c_shamt;
    logic             c_asel, c_bsel, c_wb_en, c_loads;
    logic [WIDTH-1:0] c_imm;
    logic [3:0]       c_vsel;

    logic [RW-1:0]    rd_idx;
    logic [WIDTH-1:0] rf_rdata;
    logic [WIDTH-1:0] b_sh, ain, bin, alu_res;
    logic             alu_v;
    logic [2:0]       flags;
    logic [WIDTH-1:0] wb_val;
    logic             wb_onehot, wr_ok;

    // Single read port: READA fetches rn, every other state presents rm.
    always_comb begin
        rd_idx   = (state == READA) ? c_rn : c_rm;
        rf_rdata = '0;
        if (int'(rd_idx) < NREGS)
            rf_rdata = regs[rd_idx];
    end

    always_comb begin
        b_sh = b_reg;
        case (c_shift)
            2'b01:   b_sh = b_reg << c_shamt;
            2'b10:   b_sh = b_reg >> c_shamt;
            2'b11:   b_sh = $signed(b_reg) >>> c_shamt;
            default: b_sh = b_reg;
        endcase
    end

    always_comb begin
        ain     = c_asel ? '0 : a_reg;
        bin     = c_bsel ? c_imm : b_sh;
        alu_res = '0;
        alu_v   = 1'b0;
        case (c_aluop)
            2'b00: begin
                alu_res = ain + bin;
                alu_v   = (ain[MSB] == bin[MSB]) && (alu_res[MSB] != ain[MSB]);
            end
            2'b01: begin
                alu_res = ain - bin;
                alu_v   = (ain[MSB] != bin[MSB]) && (alu_res[MSB] != ain[MSB]);
            end
            2'b10:   alu_res = ain & bin;
            default: alu_res = ~bin;
        endcase
        flags = {alu_v, alu_res[MSB], (alu_res == '0)};
    end

    always_comb begin
        wb_val    = '0;
        wb_onehot = 1'b1;
        case (c_vsel)
            4'b0001: wb_val = mdata;
            4'b0010: wb_val = c_imm;
            4'b0100: wb_val = WIDTH'(PC);
            4'b1000: wb_val = c_reg;
            default: wb_onehot = 1'b0;
        endcase
        wr_ok = c_wb_en && wb_onehot && (int'(c_rd) < NREGS);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            regs    <= '{default: '0};
            a_reg   <= '0;
            b_reg   <= '0;
            c_reg   <= '0;
            status  <= '0;
            c_rn    <= '0;
            c_rm    <= '0;
            c_rd    <= '0;
            c_aluop <= '0;
            c_shift <= '0;
            c_shamt <= '0;
            c_asel  <= 1'b0;
            c_bsel  <= 1'b0;
            c_imm   <= '0;
            c_vsel  <= '0;
            c_wb_en <= 1'b0;
            c_loads <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        c_rn    <= rn;
                        c_rm    <= rm;
                        c_rd    <= rd;
                        c_aluop <= ALUop;
                        c_shift <= shift;
                        c_shamt <= shamt;
                        c_asel  <= asel;
                        c_bsel  <= bsel;
                        c_imm   <= imm;
                        c_vsel  <= vsel;
                        c_wb_en <= wb_en;
                        c_loads <= loads;
                        busy    <= 1'b1;
                        state   <= READA;
                    end
                end
                READA: begin
                    a_reg <= rf_rdata;
                    state <= READB;
                end
                READB: begin
                    b_reg <= rf_rdata;
                    state <= EXEC;
                end
                EXEC: begin
                    c_reg <= alu_res;
                    if (c_loads)
                        status <= flags;
                    done  <= 1'b1;
                    state <= WB;
                end
                WB: begin
                    if (wr_ok)
                        regs[c_rd] <= wb_val;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign datapath_out = c_reg;
    assign Z_out        = status;

endmodule

// File: tb/tb_datapath_seq.sv
// Self-checking bench for datapath_seq: directed cases from the feature list plus
// randomized commands compared against an arithmetic reference model.
module tb_datapath_seq;

    localparam int W  = 16;
    localparam int NR = 6;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [2:0]  rn, rm, rd;
    logic [1:0]  ALUop, shift;
    logic [3:0]  shamt;
    logic        asel, bsel;
    logic [15:0] imm;
    logic [3:0]  vsel;
    logic        wb_en, loads;
    logic [15:0] mdata;
    logic [7:0]  PC;
    logic        busy, done;
    logic [15:0] datapath_out;
    logic [2:0]  Z_out;

    datapath_seq #(.WIDTH(W), .NREGS(NR), .PCW(8)) dut (
        .clk(clk), .reset(reset), .start(start), .rn(rn), .rm(rm), .rd(rd),
        .ALUop(ALUop), .shift(shift), .shamt(shamt), .asel(asel), .bsel(bsel),
        .imm(imm), .vsel(vsel), .wb_en(wb_en), .loads(loads), .mdata(mdata),
        .PC(PC), .busy(busy), .done(done), .datapath_out(datapath_out), .Z_out(Z_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  rn, rm, rd;
        logic [1:0]  aluop, shift;
        logic [3:0]  shamt;
        logic        asel, bsel;
        logic [15:0] imm;
        logic [3:0]  vsel;
        logic        wb_en, loads;
        logic [15:0] mdata;
        logic [7:0]  pc;
    } cmd_t;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int          m_regs [8];
    logic [15:0] m_c;
    logic [2:0]  m_st;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic cmd_t blank();
        cmd_t c;
        c = '{default: '0};
        return c;
    endfunction

    function automatic cmd_t mk_load(input logic [2:0] r, input logic [15:0] v);
        cmd_t c;
        c = blank();
        c.rd = r; c.imm = v; c.vsel = 4'b0010; c.wb_en = 1'b1;
        return c;
    endfunction

    // 0 + R[idx], no writeback, status untouched: C shows the register.
    function automatic cmd_t mk_read(input logic [2:0] idx);
        cmd_t c;
        c = blank();
        c.rm = idx; c.asel = 1'b1;
        return c;
    endfunction

    function automatic int sx(input int v);
        return (v >= 32768) ? v - 65536 : v;
    endfunction

    function automatic int m_read(input logic [2:0] idx);
        return (int'(idx) < NR) ? m_regs[idx] : 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 0;
        m_c  = '0;
        m_st = '0;
    endtask

    task automatic model_step(input cmd_t c);
        int a, b, bs, ain, bin, r, sr, val;
        bit v, wr;
        a = m_read(c.rn);
        b = m_read(c.rm);
        case (c.shift)
            2'd1:    bs = (b * (1 << c.shamt)) % 65536;
            2'd2:    bs = b / (1 << c.shamt);
            2'd3:    bs = (sx(b) >>> c.shamt) & 65535;
            default: bs = b;
        endcase
        ain = c.asel ? 0 : a;
        bin = c.bsel ? int'(c.imm) : bs;
        v = 0;
        case (c.aluop)
            2'd0: begin sr = sx(ain) + sx(bin); r = (ain + bin) % 65536; v = (sr > 32767) || (sr < -32768); end
            2'd1: begin sr = sx(ain) - sx(bin); r = (ain - bin + 65536) % 65536; v = (sr > 32767) || (sr < -32768); end
            2'd2: r = ain & bin;
            default: r = 65535 - bin;
        endcase
        m_c = r[15:0];
        if (c.loads) m_st = {v, (r >= 32768), (r == 0)};
        wr = 1; val = 0;
        case (c.vsel)
            4'd1: val = int'(c.mdata);
            4'd2: val = int'(c.imm);
            4'd4: val = int'(c.pc);
            4'd8: val = int'(m_c);
            default: wr = 0;
        endcase
        if (c.wb_en && wr && int'(c.rd) < NR) m_regs[c.rd] = val;
    endtask

    task automatic drive(input cmd_t c);
        rn = c.rn; rm = c.rm; rd = c.rd; ALUop = c.aluop; shift = c.shift;
        shamt = c.shamt; asel = c.asel; bsel = c.bsel; imm = c.imm; vsel = c.vsel;
        wb_en = c.wb_en; loads = c.loads; mdata = c.mdata; PC = c.pc;
    endtask

    task automatic run_cmd(input string tag, input cmd_t c);
        int first;
        first = -1;
        @(negedge clk);
        drive(c);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 16 && first < 0; i++) begin
            @(negedge clk);
            if (i == 0) check({tag, "_busy"}, 32'(busy), 32'd1);
            if (done === 1'b1) first = i;
        end
        check({tag, "_done_lat"}, first, 32'd3);
        model_step(c);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        check({tag, "_c"}, 32'(datapath_out), 32'(m_c));
        check({tag, "_st"}, 32'(Z_out), 32'(m_st));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_t c;
        int   n;
        int   pos [8];

        reset = 1'b1; start = 1'b0;
        drive(blank());
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_out", 32'(datapath_out), 32'd0);
        check("rst_st", 32'(Z_out), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            run_cmd("rst_rd", mk_read(3'(i)));
            check("rst_reg", 32'(datapath_out), 32'd0);
        end

        // Load and add with LSL on B
        run_cmd("ld0", mk_load(3'd0, 16'd7));
        run_cmd("ld1", mk_load(3'd1, 16'd2));
        c = blank();
        c.rn = 3'd0; c.rm = 3'd1; c.shift = 2'b01; c.shamt = 4'd1; c.rd = 3'd2;
        c.vsel = 4'b1000; c.wb_en = 1'b1; c.loads = 1'b1;
        run_cmd("add", c);
        check("add_c_const", 32'(datapath_out), 32'd11);
        check("add_st_const", 32'(Z_out), 32'b000);
        run_cmd("rd2", mk_read(3'd2));
        check("r2_const", 32'(datapath_out), 32'd11);

        // SUB to zero, then signed overflow
        run_cmd("ld0", mk_load(3'd0, 16'd5));
        run_cmd("ld1", mk_load(3'd1, 16'd5));
        c = blank();
        c.rn = 3'd0; c.rm = 3'd1; c.aluop = 2'b01; c.loads = 1'b1;
        run_cmd("sub", c);
        check("sub_st_const", 32'(Z_out), 32'b001);
        run_cmd("ld0", mk_load(3'd0, 16'h7FFF));
        c = blank();
        c.rn = 3'd0; c.bsel = 1'b1; c.imm = 16'd1; c.loads = 1'b1;
        run_cmd("ovf", c);
        check("ovf_c_const", 32'(datapath_out), 32'h8000);
        check("ovf_st_const", 32'(Z_out), 32'b110);

        // Shifter and MVN
        run_cmd("ld3", mk_load(3'd3, 16'h8000));
        c = mk_read(3'd3); c.shift = 2'b11; c.shamt = 4'd3; c.loads = 1'b1;
        run_cmd("asr", c);
        check("asr_const", 32'(datapath_out), 32'hF000);
        c.shift = 2'b10;
        run_cmd("lsr", c);
        check("lsr_const", 32'(datapath_out), 32'h1000);
        c = blank(); c.aluop = 2'b11; c.bsel = 1'b1; c.imm = 16'h00FF; c.loads = 1'b1;
        run_cmd("mvn", c);
        check("mvn_const", 32'(datapath_out), 32'hFF00);
        check("mvn_n", 32'(Z_out[1]), 32'd1);

        // Held start: R0 doubles each pass, exactly three commands
        run_cmd("ld0", mk_load(3'd0, 16'd3));
        c = blank(); c.vsel = 4'b1000; c.wb_en = 1'b1; c.loads = 1'b1;
        @(negedge clk);
        drive(c);
        start = 1'b1;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1 if (k == 11) start = 1'b0;
            @(negedge clk);
            if (done === 1'b1 && n < 8) begin pos[n] = k; n++; end
        end
        check("hs_count", n, 32'd3);
        check("hs_pos0", pos[0], 32'd3);
        check("hs_pos1", pos[1], 32'd8);
        check("hs_pos2", pos[2], 32'd13);
        repeat (3) model_step(c);
        check("hs_c", 32'(datapath_out), 32'(m_c));
        check("hs_c_const", 32'(datapath_out), 32'd24);
        check("hs_idle", 32'(busy), 32'd0);

        // Bad vsel leaves the target alone but still completes
        run_cmd("ld5", mk_load(3'd5, 16'hABCD));
        c = mk_load(3'd5, 16'h1111); c.vsel = 4'b0011;
        run_cmd("vsel3", c);
        c.vsel = 4'b0000;
        run_cmd("vsel0", c);
        run_cmd("rd5", mk_read(3'd5));
        check("r5_kept", 32'(datapath_out), 32'hABCD);

        // Out-of-range indices read 0 and never write
        run_cmd("ld6", mk_load(3'd6, 16'h5555));
        run_cmd("rd6", mk_read(3'd6));
        check("r6_zero", 32'(datapath_out), 32'd0);
        run_cmd("rd7", mk_read(3'd7));

        // PC and mdata writeback sources
        c = blank(); c.rd = 3'd1; c.vsel = 4'b0100; c.wb_en = 1'b1; c.pc = 8'hA5;
        run_cmd("pc", c);
        run_cmd("rd1", mk_read(3'd1));
        check("pc_const", 32'(datapath_out), 32'h00A5);
        c = blank(); c.rd = 3'd4; c.vsel = 4'b0001; c.wb_en = 1'b1; c.mdata = 16'hBEEF;
        run_cmd("md", c);
        run_cmd("rd4", mk_read(3'd4));
        check("md_const", 32'(datapath_out), 32'hBEEF);

        // Reset in EXEC aborts the command
        c = mk_load(3'd2, 16'h1234);
        @(negedge clk);
        drive(c);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_out", 32'(datapath_out), 32'd0);
        run_cmd("abort_rd", mk_read(3'd2));
        check("abort_r2", 32'(datapath_out), 32'd0);

        // Randomized commands against the model
        for (int it = 0; it < 40; it++) begin
            c.rn = 3'($urandom_range(0, 7));
            c.rm = 3'($urandom_range(0, 7));
            c.rd = 3'($urandom_range(0, 7));
            c.aluop = 2'($urandom);
            c.shift = 2'($urandom);
            c.shamt = 4'($urandom);
            c.asel = ($urandom_range(0, 3) == 0);
            c.bsel = ($urandom_range(0, 3) == 0);
            c.imm = 16'($urandom);
            n = $urandom_range(0, 4);
            c.vsel = (n < 4) ? 4'(1 << n) : 4'($urandom);
            c.wb_en = ($urandom_range(0, 3) != 0);
            c.loads = 1'($urandom);
            c.mdata = 16'($urandom);
            c.pc = 8'($urandom);
            run_cmd("rnd", c);
            if (it % 8 == 7)
                for (int i = 0; i < 8; i++) run_cmd("rnd_rd", mk_read(3'(i)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/datapath_seq.md
Name: datapath_seq

Overview:
- Parametrised successor to the 16-bit execution datapath: register file, A/B operand latches, barrel shifter on B, ALU, latched N/Z/V status, C result register and writeback mux.
- Adds a built-in command sequencer with a start/busy/done handshake. Each accepted command runs the full A-read → B-read → execute → writeback sequence with no external per-stage load strobes.
- Sits between the instruction decoder/controller and memory. It is fed operands, immediates, mdata and PC.

Parameters:
- WIDTH, 16, datapath word width (≥4).
- NREGS, 8, register-file depth (≥2); RW = $clog2(NREGS).
- PCW, 8, PC width; must be ≤ WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  command request; sampled only in IDLE.
- rn  input  RW  A-operand register index.
- rm  input  RW  B-operand register index.
- rd  input  RW  writeback register index.
- ALUop  input  2  00 ADD, 01 SUB, 10 AND, 11 MVN (~B).
- shift  input  2  00 none, 01 LSL, 10 LSR (logical), 11 ASR.
- shamt  input  $clog2(WIDTH)  shift amount; 0 = pass-through.
- asel  input  1  1 → ALU A input forced to 0.
- bsel  input  1  1 → ALU B input = imm (shifter bypassed).
- imm  input  WIDTH  sign-extended immediate; also a writeback source.
- vsel  input  4  one-hot writeback source: 0001 mdata, 0010 imm, 0100 {0,PC}, 1000 C.
- wb_en  input  1  enable register-file write in WB.
- loads  input  1  update status in EXEC.
- mdata  input  WIDTH  memory read data.
- PC  input  PCW  program counter, zero-extended to WIDTH.
- busy  output  1  high in READA, READB, EXEC and WB.
- done  output  1  one-cycle pulse, high during WB.
- datapath_out  output  WIDTH  C register.
- Z_out  output  3  status: [0] Z, [1] N, [2] V.

Behaviour:
- Reset (synchronous, highest priority):
  - state → IDLE.
  - All NREGS registers, A, B, C and status cleared to 0.
  - busy = 0, done = 0.
  - Reset during any state aborts the command; no writeback occurs.
- Command capture: in IDLE, start = 1 at an edge latches rn, rm, rd, ALUop, shift, shamt, asel, bsel, imm, vsel, wb_en and loads into a command register, then state → READA.
- mdata and PC are sampled live during WB, not latched.
- start is ignored while busy; a held start re-triggers from IDLE after WB.
- FSM, one state per cycle:
  - IDLE → READA on start.
  - READA: A ← R[rn] at exit edge.
  - READB: B ← R[rm] at exit edge.
  - EXEC: C ← ALU result. If loads, status ← flags.
  - WB: done = 1. If wb_en and vsel is one-hot, R[rd] ← selected source at exit edge. Then → IDLE.
- Latency: start seen at edge 0, done high in the cycle after edge 3, register written at edge 4. Back-to-back throughput is one command per 5 cycles.
- Register file: single read port (combinational), single write port.
  - Index ≥ NREGS reads 0.
  - Index ≥ NREGS suppresses the write.
- Shifter (applied to B):
  - LSL fills zeros.
  - LSR fills zeros.
  - ASR replicates the MSB.
  - shamt = 0 returns B unchanged for every shift code.
- ALU:
  - Operands are Ain = asel ? 0 : A and Bin = bsel ? imm : shifted B.
  - ADD/SUB are modulo 2^WIDTH.
  - Z = (result == 0).
  - N = result[WIDTH-1].
  - V = signed overflow for ADD/SUB; 0 for AND/MVN.
- Writeback mux: vsel not exactly one-hot (0000 or multi-hot) suppresses the write. It is never an X or latch.
- Timing:
  - C and status change only at the EXEC exit edge.
  - vsel = 1000 writes the C value just produced by the same command.
  - rd equal to rn/rm of the following command sees the new value, because writeback completes before the next READA.

Test Plan:
- Reset, then read via commands: all registers, datapath_out and Z_out are 0; busy = 0.
- Load and add: load R0 ← 7 and R1 ← 2 via vsel = 0010, wb_en = 1. Then ADD rn = 0, rm = 1, shift = LSL, shamt = 1, rd = 2, vsel = 1000, loads = 1. Required: done pulses 4 cycles after start, R2 = 11, Z_out = 000.
- Subtract and overflow: SUB with R0 = R1 = 5 gives C = 0, Z_out = 001. ADD 0x7FFF + 0x0001 (WIDTH = 16) gives C = 0x8000, Z_out = 110.
- Shifter: ASR of R3 = 0x8000 with shamt = 3 gives 0xF000. LSR gives 0x1000. MVN of 0x00FF gives 0xFF00 with N = 1.
- Handshake: start held high for 12 cycles gives exactly 3 done pulses, at cycles 4, 9 and 14 after the first edge. start while busy is not captured.
- Abort and bad vsel: reset asserted in EXEC means the target register is unchanged and state is IDLE next cycle. vsel = 0011 with wb_en = 1 leaves R[rd] unchanged while done still pulses.
